// File: rtl/ac97_pkg.sv
// Shared constants, tag bit positions and state type for the AC97 frame transmitter.
package ac97_pkg;

    localparam int FRAME_BITS  = 256;
    localparam int TAG_BITS    = 16;
    localparam int SLOT_BITS   = 20;

    localparam int SLOT1_START = 16;
    localparam int SLOT2_START = SLOT1_START + SLOT_BITS;
    localparam int SLOT3_START = 56;
    localparam int SLOT4_START = 76;

    localparam int TAG_FRAME_VALID = 15;
    localparam int TAG_SLOT1_VALID = 14;
    localparam int TAG_SLOT2_VALID = 13;
    localparam int TAG_SLOT3_VALID = 12;
    localparam int TAG_SLOT4_VALID = 11;

    typedef enum logic {
        S_WAIT,
        S_RUN
    } state_t;

endpackage

// File: rtl/ac97_frame_tx_if.sv
// Sample/command handshake between the upstream sound logic and the AC97 transmitter.
interface ac97_frame_tx_if #(
    parameter int SAMPLE_W = 8
);
    logic [SAMPLE_W-1:0] left_data;
    logic [SAMPLE_W-1:0] right_data;
    logic                cmd_valid;
    logic [6:0]          cmd_addr;
    logic [15:0]         cmd_data;
    logic                ready;

    modport master (
        output left_data, right_data, cmd_valid, cmd_addr, cmd_data,
        input  ready
    );

    modport slave (
        input  left_data, right_data, cmd_valid, cmd_addr, cmd_data,
        output ready
    );
endinterface

// File: rtl/ac97_slot_shifter.sv
// 256-bit shadow frame: parallel load at the frame boundary, MSB-first shift-out.
module ac97_slot_shifter
    import ac97_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [FRAME_BITS-1:0] i_frame,
    output logic                  o_bit
);

    logic [FRAME_BITS-1:0] r_shadow;

    // The flop MSB is the serial output, so bit k appears in the cycle the counter reads k.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (i_load) begin
            r_shadow <= i_frame;
        end else begin
            r_shadow <= {r_shadow[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign o_bit = r_shadow[FRAME_BITS-1];

endmodule

// File: rtl/ac97_frame_tx.sv
// AC97 link transmitter: latches samples/command per frame and serializes 256-bit frames.
// Codec register writes are enabled by defining AC97_CMD_EN; otherwise cmd_* is ignored.
module ac97_frame_tx
    import ac97_pkg::*;
#(
    parameter int SAMPLE_W   = 8,
    parameter int RESET_WAIT = 1024
)
(
    input  logic            clock,
    input  logic            reset,
    ac97_frame_tx_if.slave  bus,
    output logic            ac97_synch,
    output logic            ac97_sdata_out
);

    localparam int WAIT_W = (RESET_WAIT > 1) ? $clog2(RESET_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESET_WAIT - 1);

    state_t                r_state;
    state_t                w_nextState;
    logic                  w_load;
    logic [WAIT_W-1:0]     r_waitCnt;
    logic [7:0]            r_bitCnt;
    logic                  r_ready;
    logic                  r_synch;
    logic                  w_cmdValid;
    logic [TAG_BITS-1:0]   w_tag;
    logic [SLOT_BITS-1:0]  w_slot1;
    logic [SLOT_BITS-1:0]  w_slot2;
    logic [SLOT_BITS-1:0]  w_slot3;
    logic [SLOT_BITS-1:0]  w_slot4;
    logic [FRAME_BITS-1:0] w_frame;

`ifdef AC97_CMD_EN
    assign w_cmdValid = bus.cmd_valid;
`else
    logic w_unusedCmd;
    assign w_unusedCmd = ^{bus.cmd_valid, bus.cmd_addr, bus.cmd_data};
    assign w_cmdValid  = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A frame loads whenever the bit counter is about to read 0, including leaving S_WAIT.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (r_waitCnt == WAIT_LAST) begin
                    w_nextState = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (r_bitCnt == 8'hFF) begin
                    w_load = 1'b1;
                end
            end
            default: w_nextState = S_WAIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_waitCnt <= '0;
            r_bitCnt  <= '0;
            r_ready   <= 1'b0;
            r_synch   <= 1'b0;
        end else begin
            if (w_load) begin
                r_waitCnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end
            if (r_state == S_RUN) begin
                r_bitCnt <= r_bitCnt + 1'b1;
            end
            r_ready <= w_load;
            r_synch <= w_load || ((r_state == S_RUN) && (r_bitCnt < 8'(TAG_BITS - 1)));
        end
    end

    // Frame index FRAME_BITS-1-k holds bit k, so each field is placed MSB-first.
    always_comb begin
        w_tag                  = '0;
        w_tag[TAG_FRAME_VALID] = 1'b1;
        w_tag[TAG_SLOT1_VALID] = w_cmdValid;
        w_tag[TAG_SLOT2_VALID] = w_cmdValid;
        w_tag[TAG_SLOT3_VALID] = 1'b1;
        w_tag[TAG_SLOT4_VALID] = 1'b1;
        w_slot1 = w_cmdValid ? {1'b0, bus.cmd_addr, 12'b0} : '0;
        w_slot2 = w_cmdValid ? {bus.cmd_data, 4'b0} : '0;
        w_slot3 = SLOT_BITS'(bus.left_data)  << (SLOT_BITS - SAMPLE_W);
        w_slot4 = SLOT_BITS'(bus.right_data) << (SLOT_BITS - SAMPLE_W);
        w_frame = '0;
        w_frame[FRAME_BITS-1 -: TAG_BITS]               = w_tag;
        w_frame[FRAME_BITS-1-SLOT1_START -: SLOT_BITS]  = w_slot1;
        w_frame[FRAME_BITS-1-SLOT2_START -: SLOT_BITS]  = w_slot2;
        w_frame[FRAME_BITS-1-SLOT3_START -: SLOT_BITS]  = w_slot3;
        w_frame[FRAME_BITS-1-SLOT4_START -: SLOT_BITS]  = w_slot4;
    end

    ac97_slot_shifter u_shifter (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_load),
        .i_frame (w_frame),
        .o_bit   (ac97_sdata_out)
    );

    assign ac97_synch = r_synch;
    assign bus.ready  = r_ready;

endmodule
